dds_phase_accum: RTL and testbench

- Numerically controlled phase accumulator that feeds the DDS sine ROM lookup stage.
- Advances a PHASE_WDTH-bit phase by a frequency tuning word (FTW) on each sample-rate tick.
- Drives the packed {neg, inv, addr, cntr} lookup index directly on sine_lookup.
- Accepts FTW updates over a valid/ready handshake, applied either immediately or glitch-free at phase wrap. Provides valid strobes aligned to both the index and the ROM's 1-cycle registered output.

---
 rtl/dds_pkg.sv | 13 +
 rtl/dds_ftw_slot.sv | 53 +++++
 rtl/dds_phase_accum.sv | 93 +++++++++
 tb/tb_dds_phase_accum.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared widths and slot state encoding for the DDS phase accumulator.
package dds_pkg;

    localparam int DDS_ADDR_WDTH  = 12;
    localparam int DDS_CNTR_WDTH  = 4;
    localparam int DDS_PHASE_WDTH = DDS_ADDR_WDTH + DDS_CNTR_WDTH;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/dds_ftw_slot.sv
// Single-entry valid/ready holding register for a pending tuning word.
module dds_ftw_slot
    import dds_pkg::*;
#(
    parameter int DATA_WDTH = DDS_PHASE_WDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [DATA_WDTH-1:0] in_data,
    output logic                 in_ready,
    input  logic                 transfer,
    output logic                 full,
    output logic [DATA_WDTH-1:0] out_data
);

    slot_state_e          state_q, state_d;
    logic [DATA_WDTH-1:0] data_q, data_d;

    // Ready is a pure decode of the state flop, so it never depends on
    // same-cycle inputs and no accept can happen in the transfer cycle.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            EMPTY: begin
                if (in_valid) begin
                    state_d = FULL;
                    data_d  = in_data;
                end
            end
            FULL: begin
                if (transfer) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign in_ready = (state_q == EMPTY);
    assign full     = (state_q == FULL);
    assign out_data = data_q;

endmodule

// File: rtl/dds_phase_accum.sv
// DDS phase accumulator: FTW-stepped phase index with wrap flag and
// valid strobes aligned to the index and to the registered sine ROM.
module dds_phase_accum
    import dds_pkg::*;
#(
    parameter int ADDR_WDTH  = DDS_ADDR_WDTH,
    parameter int CNTR_WDTH  = DDS_CNTR_WDTH,
    parameter int PHASE_WDTH = ADDR_WDTH + CNTR_WDTH,
    parameter int FTW_WDTH   = PHASE_WDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_tick,
    input  logic                  enable,
    input  logic                  sync_mode,
    input  logic                  phase_clr,
    input  logic [FTW_WDTH-1:0]   ftw_data,
    input  logic                  ftw_valid,
    output logic                  ftw_ready,
    output logic [PHASE_WDTH-1:0] sine_lookup,
    output logic                  lookup_valid,
    output logic                  value_valid,
    output logic                  wrap
);

    logic [PHASE_WDTH-1:0] phase_q, phase_d;
    logic [FTW_WDTH-1:0]   ftw_active_q, ftw_active_d;
    logic                  wrap_q, wrap_d;
    logic [2:1]            vld_pipe_q, vld_pipe_d;

    logic                  tick_en;
    logic [PHASE_WDTH:0]   sum;
    logic                  carry;
    logic                  slot_full;
    logic                  transfer;
    logic [FTW_WDTH-1:0]   slot_data;

    assign tick_en = sample_tick & enable;
    assign sum     = {1'b0, phase_q} + (PHASE_WDTH+1)'(ftw_active_q);
    assign carry   = sum[PHASE_WDTH];

    // In sync mode the new word lands only on a phase discontinuity that
    // already happens (wrap or clear), keeping the output glitch-free.
    assign transfer = tick_en & slot_full & (~sync_mode | phase_clr | carry);

    dds_ftw_slot #(
        .DATA_WDTH (FTW_WDTH)
    ) u_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (ftw_valid),
        .in_data  (ftw_data),
        .in_ready (ftw_ready),
        .transfer (transfer),
        .full     (slot_full),
        .out_data (slot_data)
    );

    always_comb begin
        phase_d      = phase_q;
        ftw_active_d = transfer ? slot_data : ftw_active_q;
        wrap_d       = 1'b0;
        vld_pipe_d   = {vld_pipe_q[1], tick_en};
        if (tick_en) begin
            if (phase_clr) begin
                phase_d = '0;
            end else begin
                phase_d = sum[PHASE_WDTH-1:0];
                wrap_d  = carry;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= '0;
            ftw_active_q <= '0;
            wrap_q       <= 1'b0;
            vld_pipe_q   <= '0;
        end else begin
            phase_q      <= phase_d;
            ftw_active_q <= ftw_active_d;
            wrap_q       <= wrap_d;
            vld_pipe_q   <= vld_pipe_d;
        end
    end

    assign sine_lookup  = phase_q;
    assign lookup_valid = vld_pipe_q[1];
    assign value_valid  = vld_pipe_q[2];
    assign wrap         = wrap_q;

endmodule

// File: tb/tb_dds_phase_accum.sv
// Scenario bench for dds_phase_accum with an expected-result queue.
module tb_dds_phase_accum;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        sample_tick = 1'b0;
    logic        enable = 1'b0;
    logic        sync_mode = 1'b0;
    logic        phase_clr = 1'b0;
    logic [15:0] ftw_data = '0;
    logic        ftw_valid = 1'b0;
    logic        ftw_ready;
    logic [15:0] sine_lookup;
    logic        lookup_valid;
    logic        value_valid;
    logic        wrap;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [15:0] ph;
        logic        wr;
    } exp_t;

    exp_t exp_q[$];

    dds_phase_accum dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_tick  (sample_tick),
        .enable       (enable),
        .sync_mode    (sync_mode),
        .phase_clr    (phase_clr),
        .ftw_data     (ftw_data),
        .ftw_valid    (ftw_valid),
        .ftw_ready    (ftw_ready),
        .sine_lookup  (sine_lookup),
        .lookup_valid (lookup_valid),
        .value_valid  (value_valid),
        .wrap         (wrap)
    );

    always #5 clk = ~clk;

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic tick(input logic clr);
        sample_tick = 1'b1; enable = 1'b1; phase_clr = clr;
        @(posedge clk); #1;
        sample_tick = 1'b0; phase_clr = 1'b0;
    endtask

    task automatic push_exp(input logic [15:0] ph, input logic wr);
        exp_t e;
        e.ph = ph; e.wr = wr;
        exp_q.push_back(e);
    endtask

    task automatic send_ftw(input logic [15:0] d);
        int n = 0;
        ftw_valid = 1'b1; ftw_data = d;
        while (!ftw_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        ftw_valid = 1'b0;
        n_chk++;
        if (n >= 20) begin
            n_fail++;
            $display("FAIL send_ftw_timeout: ftw_ready=%b after %0d cycles, required 1", ftw_ready, n);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #2;
        n_chk++;
        if ({ftw_ready, lookup_valid, value_valid, wrap} !== 4'b1000 || sine_lookup !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_values: rdy=%b lv=%b vv=%b wr=%b ph=%h, required 1 0 0 0 0000",
                     ftw_ready, lookup_valid, value_valid, wrap, sine_lookup);
        end
        @(posedge clk); #1; rst_n = 1'b1;
        idle();
        n_chk++;
        if ({lookup_valid, value_valid, wrap} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_release: lv=%b vv=%b wr=%b, required 000", lookup_valid, value_valid, wrap);
        end
    endtask

    task automatic test_immediate();
        exp_t e;
        sync_mode = 1'b0;
        send_ftw(16'h1000);
        for (int i = 0; i < 17; i++) begin
            push_exp(16'(i * 32'h1000), i == 16);
            tick(1'b0);
            e = exp_q.pop_front();
            n_chk++;
            if (!lookup_valid || value_valid || sine_lookup !== e.ph || wrap !== e.wr) begin
                n_fail++;
                $display("FAIL imm_tick%0d: lv=%b vv=%b ph=%h wr=%b, required lv=1 vv=0 ph=%h wr=%b",
                         i, lookup_valid, value_valid, sine_lookup, wrap, e.ph, e.wr);
            end
            idle();
            n_chk++;
            if (lookup_valid || !value_valid || wrap) begin
                n_fail++;
                $display("FAIL imm_trail%0d: lv=%b vv=%b wr=%b, required 0 1 0", i, lookup_valid, value_valid, wrap);
            end
        end
    endtask

    task automatic test_sync();
        exp_t e;
        sync_mode = 1'b0;
        send_ftw(16'h4000);
        push_exp(16'h0000, 1'b0); tick(1'b1); idle();
        push_exp(16'h4000, 1'b0); tick(1'b0); idle();
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            n_chk++;
            if (e.ph !== 16'h0 && sine_lookup !== e.ph) begin
                n_fail++;
                $display("FAIL sync_setup: ph=%h, required %h", sine_lookup, e.ph);
            end
        end
        sync_mode = 1'b1;
        send_ftw(16'h0100);
        push_exp(16'h8000, 1'b0);
        push_exp(16'hC000, 1'b0);
        push_exp(16'h0000, 1'b1);
        push_exp(16'h0100, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0);
            e = exp_q.pop_front();
            n_chk++;
            if (!lookup_valid || sine_lookup !== e.ph || wrap !== e.wr) begin
                n_fail++;
                $display("FAIL sync_tick%0d: lv=%b ph=%h wr=%b, required lv=1 ph=%h wr=%b",
                         i, lookup_valid, sine_lookup, wrap, e.ph, e.wr);
            end
            n_chk++;
            if (ftw_ready !== (i >= 2)) begin
                n_fail++;
                $display("FAIL sync_ready%0d: ftw_ready=%b, required %b", i, ftw_ready, i >= 2);
            end
            idle();
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        sync_mode = 1'b1;
        send_ftw(16'h0200);
        ftw_valid = 1'b1; ftw_data = 16'h0ABC;
        for (int i = 0; i < 3; i++) begin
            idle();
            n_chk++;
            if (ftw_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: ftw_ready=%b, required 0", i, ftw_ready);
            end
        end
        push_exp(16'h0000, 1'b0);
        tick(1'b1);
        e = exp_q.pop_front();
        n_chk++;
        if (sine_lookup !== e.ph || wrap !== e.wr || ftw_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_clr: ph=%h wr=%b rdy=%b, required ph=%h wr=%b rdy=1",
                     sine_lookup, wrap, ftw_ready, e.ph, e.wr);
        end
        idle();
        ftw_valid = 1'b0;
        n_chk++;
        if (ftw_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_accept: ftw_ready=%b, required 0", ftw_ready);
        end
        sync_mode = 1'b0;
        push_exp(16'h0200, 1'b0);
        push_exp(16'h0CBC, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick(1'b0);
            e = exp_q.pop_front();
            n_chk++;
            if (!lookup_valid || sine_lookup !== e.ph || wrap !== e.wr) begin
                n_fail++;
                $display("FAIL bp_data%0d: ph=%h wr=%b, required ph=%h wr=%b", i, sine_lookup, wrap, e.ph, e.wr);
            end
        end
        idle(); idle();
    endtask

    task automatic test_enable_clr();
        exp_t e;
        sync_mode = 1'b0;
        send_ftw(16'h3000);
        tick(1'b1);
        push_exp(16'h3000, 1'b0);
        tick(1'b0);
        send_ftw(16'h0111);
        idle(); idle();
        e = exp_q.pop_front();
        sample_tick = 1'b1; enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle();
            n_chk++;
            if (sine_lookup !== e.ph || lookup_valid || value_valid || ftw_ready) begin
                n_fail++;
                $display("FAIL en_off%0d: ph=%h lv=%b vv=%b rdy=%b, required ph=%h lv=0 vv=0 rdy=0",
                         i, sine_lookup, lookup_valid, value_valid, ftw_ready, e.ph);
            end
        end
        sample_tick = 1'b0;
        push_exp(16'h0000, 1'b0);
        push_exp(16'h0111, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick(i == 0);
            e = exp_q.pop_front();
            n_chk++;
            if (!lookup_valid || sine_lookup !== e.ph || wrap !== e.wr || !ftw_ready) begin
                n_fail++;
                $display("FAIL en_clr%0d: lv=%b ph=%h wr=%b rdy=%b, required lv=1 ph=%h wr=%b rdy=1",
                         i, lookup_valid, sine_lookup, wrap, ftw_ready, e.ph, e.wr);
            end
        end
        idle(); idle();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        sync_mode = 1'b1;
        send_ftw(16'h2000);
        push_exp(16'h0222, 1'b0);
        tick(1'b0);
        e = exp_q.pop_front();
        n_chk++;
        if (!lookup_valid || sine_lookup !== e.ph || ftw_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_pre: lv=%b ph=%h rdy=%b, required lv=1 ph=%h rdy=0", lookup_valid, sine_lookup, ftw_ready, e.ph);
        end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({ftw_ready, lookup_valid, value_valid, wrap} !== 4'b1000 || sine_lookup !== 16'h0) begin
            n_fail++;
            $display("FAIL rst_mid: rdy=%b lv=%b vv=%b wr=%b ph=%h, required 1 0 0 0 0000",
                     ftw_ready, lookup_valid, value_valid, wrap, sine_lookup);
        end
        @(posedge clk); #1; rst_n = 1'b1;
        sync_mode = 1'b0;
        idle();
        n_chk++;
        if (lookup_valid || value_valid) begin
            n_fail++;
            $display("FAIL rst_mid_release: lv=%b vv=%b, required 0 0", lookup_valid, value_valid);
        end
        push_exp(16'h0000, 1'b0);
        push_exp(16'h0000, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick(1'b0);
            e = exp_q.pop_front();
            n_chk++;
            if (!lookup_valid || sine_lookup !== e.ph || wrap !== e.wr) begin
                n_fail++;
                $display("FAIL rst_after%0d: lv=%b ph=%h wr=%b, required lv=1 ph=%h wr=%b",
                         i, lookup_valid, sine_lookup, wrap, e.ph, e.wr);
            end
        end
        idle(); idle();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        sync_mode = 1'b0;
        send_ftw(16'hFFFF);
        tick(1'b1);
        idle(); idle();
        push_exp(16'hFFFF, 1'b0);
        push_exp(16'hFFFE, 1'b1);
        push_exp(16'hFFFD, 1'b1);
        sample_tick = 1'b1; enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i == 2) sample_tick = 1'b0;
            e = exp_q.pop_front();
            n_chk++;
            if (!lookup_valid || value_valid !== (i > 0) || sine_lookup !== e.ph || wrap !== e.wr) begin
                n_fail++;
                $display("FAIL b2b_tick%0d: lv=%b vv=%b ph=%h wr=%b, required lv=1 vv=%b ph=%h wr=%b",
                         i, lookup_valid, value_valid, sine_lookup, wrap, i > 0, e.ph, e.wr);
            end
        end
        idle();
        n_chk++;
        if (lookup_valid || !value_valid || wrap || sine_lookup !== 16'hFFFD) begin
            n_fail++;
            $display("FAIL b2b_tail: lv=%b vv=%b wr=%b ph=%h, required 0 1 0 fffd",
                     lookup_valid, value_valid, wrap, sine_lookup);
        end
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_sync();
        test_backpressure();
        test_enable_clr();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
